// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Includes the fetch FSM state encoding, width defaults and the sequential PC increment.
package riscv_pkg;

   localparam int unsigned DEF_ADDR_WIDTH  = 32;
   localparam int unsigned DEF_INSTR_WIDTH = 32;
   localparam int unsigned PC_INCR         = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_ERR
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Next-PC selection: sequential PC+4 or taken branch PC+imm (modular add).
// Flags taken targets that are not word aligned.
module pc_next
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic                  pc_src_i,
   input  logic [ADDR_WIDTH-1:0] imm_ext_i,
   output logic [ADDR_WIDTH-1:0] next_pc_o,
   output logic                  misalign_o
);

   logic [ADDR_WIDTH-1:0] offset;

   always_comb begin
      offset     = pc_src_i ? imm_ext_i : ADDR_WIDTH'(PC_INCR);
      next_pc_o  = pc_i + offset;
      misalign_o = pc_src_i && (next_pc_o[1:0] != 2'b00);
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests instructions from instruction memory and
// holds each one for the control unit until it is retired.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned           INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   imem_req_o,
   output logic [ADDR_WIDTH-1:0]  imem_addr_o,
   input  logic                   imem_gnt_i,
   input  logic                   imem_rvalid_i,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic                   instr_valid_o,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   input  logic                   instr_done_i,
   input  logic                   pc_src_i,
   input  logic [ADDR_WIDTH-1:0]  imm_ext_i,
   output logic                   misalign_o
);

   fetch_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  next_pc;
   logic                   next_misalign;

   pc_next #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_next (
      .pc_i       (pc_q),
      .pc_src_i   (pc_src_i),
      .imm_ext_i  (imm_ext_i),
      .next_pc_o  (next_pc),
      .misalign_o (next_misalign)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_gnt_i && imem_rvalid_i) begin
               instr_d = imem_rdata_i;
               state_d = S_HOLD;
            end else if (imem_gnt_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               instr_d = imem_rdata_i;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            // A misaligned taken target freezes the PC at the offending branch.
            if (instr_done_i) begin
               if (next_misalign) begin
                  state_d = S_ERR;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_REQ;
               end
            end
         end
         S_ERR: state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req_o    = (state_q == S_REQ);
   assign imem_addr_o   = pc_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = (state_q == S_HOLD);
   assign pc_o          = pc_q;
   assign misalign_o    = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with RESET_PC = 0x100.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic        instr_done;
   logic        pc_src;
   logic [31:0] imm_ext;
   logic        misalign;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   instr_fetch_unit #(
      .ADDR_WIDTH  (32),
      .INSTR_WIDTH (32),
      .RESET_PC    (32'h0000_0100)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .instr_o       (instr),
      .instr_valid_o (instr_valid),
      .pc_o          (pc),
      .instr_done_i  (instr_done),
      .pc_src_i      (pc_src),
      .imm_ext_i     (imm_ext),
      .misalign_o    (misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_done = 1'b0; pc_src = 1'b0; imm_ext = '0;
      step(); step();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_pc", pc, 32'h100);

      // 1: IDLE one cycle, then request at RESET_PC
      rst = 1'b0;
      step(); settle();
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'h100);

      // 2: zero-wait fetch, spurious rvalid in HOLD, sequential retire
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; settle();
      chk("t2_valid", 32'(instr_valid), 32'd1);
      chk("t2_instr", instr, 32'h0050_0093);
      chk("t2_pc", pc, 32'h100);
      chk("t2_req_hold", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0; settle();
      chk("t2_spur_instr", instr, 32'h0050_0093);
      chk("t2_spur_valid", 32'(instr_valid), 32'd1);
      instr_done = 1'b1; pc_src = 1'b0;
      step();
      instr_done = 1'b0; settle();
      chk("t2_valid_drop", 32'(instr_valid), 32'd0);
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_next_addr", imem_addr, 32'h104);

      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_done = 1'b1;
      step();
      instr_done = 1'b0; settle();
      chk("t2b_addr", imem_addr, 32'h108);
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; settle();
      chk("t3_pc", pc, 32'h108);

      // 3: backward taken branch
      instr_done = 1'b1; pc_src = 1'b1; imm_ext = 32'hFFFF_FFF8;
      step();
      instr_done = 1'b0; pc_src = 1'b0; imm_ext = '0; settle();
      chk("t3_addr", imem_addr, 32'h100);
      chk("t3_misalign", 32'(misalign), 32'd0);

      // 4: no grant for 3 cycles (done outside HOLD ignored), then rvalid 2 cycles after gnt
      instr_done = 1'b1; pc_src = 1'b1; imm_ext = 32'h40;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_req_nogt", 32'(imem_req), 32'd1);
         chk("t4_addr_nogt", imem_addr, 32'h100);
      end
      instr_done = 1'b0; pc_src = 1'b0; imm_ext = '0;
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; settle();
      chk("t4_req_wait", 32'(imem_req), 32'd0);
      chk("t4_valid_wait", 32'(instr_valid), 32'd0);
      step();
      chk("t4_req_wait2", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
      step();
      imem_rvalid = 1'b0; settle();
      chk("t4_valid", 32'(instr_valid), 32'd1);
      chk("t4_instr", instr, 32'h3333_3333);
      chk("t4_pc", pc, 32'h100);

      // 5: wrap-around and misaligned taken target
      instr_done = 1'b1; pc_src = 1'b1; imm_ext = 32'hFFFF_FEFC;
      step();
      instr_done = 1'b0; pc_src = 1'b0; imm_ext = '0; settle();
      chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; settle();
      chk("t5_pc_top", pc, 32'hFFFF_FFFC);
      instr_done = 1'b1;
      step();
      instr_done = 1'b0; settle();
      chk("t5_wrap_addr", imem_addr, 32'h0);
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      instr_done = 1'b1; pc_src = 1'b1; imm_ext = 32'h6;
      step();
      instr_done = 1'b0; pc_src = 1'b0; imm_ext = '0; settle();
      chk("t5_misalign", 32'(misalign), 32'd1);
      chk("t5_err_req", 32'(imem_req), 32'd0);
      chk("t5_err_valid", 32'(instr_valid), 32'd0);
      chk("t5_err_pc", pc, 32'h0);
      imem_gnt = 1'b1; imem_rvalid = 1'b1; instr_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_err_req_stay", 32'(imem_req), 32'd0);
         chk("t5_err_sticky", 32'(misalign), 32'd1);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_done = 1'b0;

      // 6: async reset clears ERR; then reset during WAIT with rvalid arriving
      #2 rst = 1'b1; settle();
      chk("t6_async_misalign", 32'(misalign), 32'd0);
      chk("t6_async_pc", pc, 32'h100);
      step();
      rst = 1'b0;
      step(); settle();
      chk("t6_req", 32'(imem_req), 32'd1);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; settle();
      chk("t6_wait_req", 32'(imem_req), 32'd0);
      rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
      step();
      chk("t6_rst_valid", 32'(instr_valid), 32'd0);
      chk("t6_rst_instr", instr, 32'h0);
      chk("t6_rst_req", 32'(imem_req), 32'd0);
      rst = 1'b0;
      step();
      chk("t6_refetch_req", 32'(imem_req), 32'd1);
      chk("t6_refetch_addr", imem_addr, 32'h100);
      step();
      chk("t6_late_valid", 32'(instr_valid), 32'd0);
      chk("t6_late_instr", instr, 32'h0);
      imem_gnt = 1'b1; imem_rdata = 32'h6666_6666;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; settle();
      chk("t6_instr", instr, 32'h6666_6666);
      chk("t6_valid", 32'(instr_valid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
